sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-master to one-slave arbiter for the sram-like memory bus. It shares a single downstream port (cache or AXI bridge) between the instruction-fetch master and the mem-stage data master. It allows one outstanding transaction at a time, gives data priority with a bounded-starvation guarantee for fetch, and steers `addr_ok`/`data_ok` only to the owning master. It sits between the CPU core and the memory subsystem, directly downstream of the mem stage's `data_*` port.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive lost arbitrations after which the inst master wins once.

Ports (`m` = `inst` or `data`; all master ports exist for both masters):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m_req`  in  1  master request; held with its payload until `m_addr_ok`.
- `m_wr`  in  1  write when 1.
- `m_size`  in  2  0 = byte, 1 = half, 2 = word.
- `m_addr`  in  32  physical address.
- `m_wdata`  in  32  store data.
- `m_uncached`  in  1  uncached attribute.
- `m_rdata`  out  32  read data; both masters driven from `s_rdata`.
- `m_addr_ok`  out  1  request accepted; asserted only to the granted master.
- `m_data_ok`  out  1  transaction complete; asserted only to the owner.
- `s_req`, `s_wr`, `s_size`, `s_addr`, `s_wdata`, `s_uncached`  out  1/1/2/32/32/1  slave request.
- `s_rdata`  in  32, `s_addr_ok`  in  1, `s_data_ok`  in  1  slave response.

## Operation
- States: IDLE, WAIT_ADDR, WAIT_DATA. A registered `owner` field takes values INST or DATA.
- IDLE, grant selection (combinational):
  - Data wins if `data_req` is set, unless `inst_req` is set and `starve_cnt == STARVE_LIMIT`; then inst wins.
  - Otherwise inst wins if `inst_req` is set.
  - With no request, `s_req = 0`.
- The granted master's payload is muxed to `s_*`. `s_addr_ok` is forwarded to the granted master only.
- IDLE transitions:
  - `s_addr_ok` and `s_data_ok` in the same cycle: forward both to the granted master and stay in IDLE.
  - `s_addr_ok` alone: latch the grant into `owner` and go to WAIT_DATA.
  - Request present without `s_addr_ok`: latch `owner` and go to WAIT_ADDR.
- WAIT_ADDR:
  - Grant is locked to `owner`. The payload is still muxed from the `owner` master, which the protocol requires to be held stable.
  - `s_req = 1`.
  - On `s_addr_ok`: forward it to `owner` and go to WAIT_DATA; or go to IDLE if `s_data_ok` arrives in the same cycle.
- WAIT_DATA:
  - `s_req = 0`; no `m_addr_ok` is asserted.
  - On `s_data_ok`: assert `owner_data_ok` and go to IDLE. The next arbitration happens the following cycle.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - Increments, saturating at `STARVE_LIMIT`, on each IDLE acceptance (`s_addr_ok`) granted to data while `inst_req = 1`.
  - Clears on any acceptance granted to inst.
  - Otherwise holds.
- `s_data_ok` in IDLE with no acceptance in the same cycle is a slave protocol error. It is ignored: no `m_data_ok` is asserted.
- `m_rdata = s_rdata` at all times. Masters qualify the data with their own `data_ok`.

## Timing
- Reset values:
  - State IDLE, `owner = INST`, `starve_cnt = 0`.
  - All `m_addr_ok` and `m_data_ok` outputs are 0.
  - `s_req`, `s_wr`, `s_size`, `s_addr`, `s_wdata` and `s_uncached` are all 0.
  - `m_rdata` follows `s_rdata`.
- Reset is asynchronous and may be asserted mid-transaction. Any in-flight transaction is dropped, and the slave is reset from the same source.
- Latencies:
  - Request to `s_req` is 0 cycles (combinational in IDLE).
  - `s_addr_ok` and `s_data_ok` reach the owner as 0-cycle pass-throughs.
- Minimum back-to-back issue is one new acceptance per two cycles. The exception is a zero-latency slave (`addr_ok` with `data_ok`), which allows one per cycle.
- No combinational path from `m_addr_ok` or `m_data_ok` back into the grant logic except through the state registers.

## Structure
- Add to `define.vh`:
  - a state typedef (`ARB_IDLE`, `ARB_WAIT_ADDR`, `ARB_WAIT_DATA`);
  - an owner typedef (`ARB_INST`, `ARB_DATA`);
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
- Single module. Grant selection may be factored into the sub-module `sram_arb_pick` (pure combinational, inputs `inst_req`, `data_req`, `starved`), which is optional.

## Test plan
- Data only: `data_req`, addr `0x1000_0004`, LW, slave `addr_ok` at +2, `data_ok` at +5 with `0xDEADBEEF` → `data_addr_ok` once, `data_data_ok` once with `m_rdata = 0xDEADBEEF`, `inst_*_ok` stay 0.
- Simultaneous requests in IDLE → data granted first; inst issued in the cycle after data's `data_ok`; `starve_cnt = 1`, then cleared to 0.
- Data holds `req` continuously for 5 transactions while inst waits, with `STARVE_LIMIT = 4` → transactions 1–4 to data, 5th acceptance to inst, then data again.
- Slave withholds `addr_ok` for 3 cycles while the other master raises `req` → grant stays locked; `s_addr`/`s_wr` stay equal to the owner's; the late requester gets no `addr_ok`.
- Zero-latency slave asserts `addr_ok` and `data_ok` in the same cycle for an inst SW of `0x12345678` → both asserted to inst in that cycle, state stays IDLE, next request accepted the next cycle.
- `rst` driven low in WAIT_DATA → immediately IDLE, all outputs 0; a late `s_data_ok` after release produces no `m_data_ok`.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and encodings for the two-master sram-like bus arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WAIT_ADDR = 2'd1,
    ARB_WAIT_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_INST = 1'b0,
    ARB_DATA = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection: data has priority unless the inst master has been starved.
module sram_arb_pick (
  input  logic inst_req,
  input  logic data_req,
  input  logic starved,
  output logic grant_valid,
  output logic grant_data
);

  // Pure combinational pick; starvation only matters while inst is actually asking.
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_data  = data_req & ~(inst_req & starved);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master to one-slave sram-like bus arbiter, one outstanding transaction.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_uncached,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // mem-stage data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // downstream slave
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_uncached,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

  logic       grant_valid;
  logic       grant_data;
  logic       starved;
  arb_owner_e sel;
  logic       fwd_addr_ok;
  logic       fwd_data_ok;

  assign starved = (starve_cnt_q == CntW'(STARVE_LIMIT));

  sram_arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .starved     (starved),
    .grant_valid (grant_valid),
    .grant_data  (grant_data)
  );

  // Next-state, starvation counter and response steering.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    s_req        = 1'b0;
    sel          = owner_q;
    fwd_addr_ok  = 1'b0;
    fwd_data_ok  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        sel = grant_data ? ARB_DATA : ARB_INST;
        if (grant_valid) begin
          s_req       = 1'b1;
          fwd_addr_ok = s_addr_ok;
          // A lone s_data_ok here is a slave error and is dropped.
          fwd_data_ok = s_addr_ok & s_data_ok;
          owner_d     = sel;
          if (!s_addr_ok) begin
            state_d = ARB_WAIT_ADDR;
          end else if (!s_data_ok) begin
            state_d = ARB_WAIT_DATA;
          end
          if (s_addr_ok) begin
            if (sel == ARB_INST) begin
              starve_cnt_d = '0;
            end else if (inst_req && !starved) begin
              starve_cnt_d = starve_cnt_q + CntW'(1);
            end
          end
        end
      end
      ARB_WAIT_ADDR: begin
        s_req       = 1'b1;
        fwd_addr_ok = s_addr_ok;
        fwd_data_ok = s_addr_ok & s_data_ok;
        if (s_addr_ok) begin
          state_d = s_data_ok ? ARB_IDLE : ARB_WAIT_DATA;
          if (owner_q == ARB_INST) begin
            starve_cnt_d = '0;
          end
        end
      end
      ARB_WAIT_DATA: begin
        fwd_data_ok = s_data_ok;
        if (s_data_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Payload mux; the bus idles at zero whenever no request is presented.
  always_comb begin
    s_wr       = 1'b0;
    s_size     = 2'd0;
    s_addr     = 32'd0;
    s_wdata    = 32'd0;
    s_uncached = 1'b0;
    if (s_req) begin
      if (sel == ARB_DATA) begin
        s_wr       = data_wr;
        s_size     = data_size;
        s_addr     = data_addr;
        s_wdata    = data_wdata;
        s_uncached = data_uncached;
      end else begin
        s_wr       = inst_wr;
        s_size     = inst_size;
        s_addr     = inst_addr;
        s_wdata    = inst_wdata;
        s_uncached = inst_uncached;
      end
    end
  end

  // Handshakes go to the selected master only; read data is broadcast.
  always_comb begin
    inst_addr_ok = fwd_addr_ok & (sel == ARB_INST);
    data_addr_ok = fwd_addr_ok & (sel == ARB_DATA);
    inst_data_ok = fwd_data_ok & (sel == ARB_INST);
    data_data_ok = fwd_data_ok & (sel == ARB_DATA);
    inst_rdata   = s_rdata;
    data_rdata   = s_rdata;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_INST;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: IDLE-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_sram_arbiter;

  localparam logic [31:0] IA = 32'h0000_0100;
  localparam logic [31:0] DA = 32'h1000_0004;
  localparam logic [31:0] IW = 32'h1234_5678;
  localparam logic [31:0] DW = 32'h5555_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_uncached;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr, data_uncached;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        s_req, s_wr, s_uncached;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_addr_ok, s_data_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_wr       (inst_wr),
    .inst_size     (inst_size),
    .inst_addr     (inst_addr),
    .inst_wdata    (inst_wdata),
    .inst_uncached (inst_uncached),
    .inst_rdata    (inst_rdata),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_uncached (data_uncached),
    .data_rdata    (data_rdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .s_req         (s_req),
    .s_wr          (s_wr),
    .s_size        (s_size),
    .s_addr        (s_addr),
    .s_wdata       (s_wdata),
    .s_uncached    (s_uncached),
    .s_rdata       (s_rdata),
    .s_addr_ok     (s_addr_ok),
    .s_data_ok     (s_data_ok)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        iwr;
    logic        dwr;
    logic        sa;
    logic        sd;
    logic [31:0] srd;
    logic [4:0]  ok;     // {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [1:0]  ssize;
    logic        swr;
    logic        sunc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic logic [4:0] oks();
    return {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One cycle: drive slave response, sample at negedge, advance past posedge.
  task automatic step(input string name, input logic sa, input logic sd, input logic [31:0] srd,
                      input logic [4:0] exp_ok, input logic [31:0] exp_addr,
                      input logic exp_wr);
    s_addr_ok = sa;
    s_data_ok = sd;
    s_rdata   = srd;
    @(negedge clk);
    chk({name, " oks"}, 32'(oks()), 32'(exp_ok));
    chk({name, " s_addr"}, s_addr, exp_addr);
    chk({name, " s_wr"}, 32'(s_wr), 32'(exp_wr));
    chk({name, " data_rdata"}, data_rdata, srd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    inst_req  = 1'b0;
    data_req  = 1'b0;
    inst_wr   = 1'b0;
    data_wr   = 1'b0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    inst_size     = 2'd2;
    inst_addr     = IA;
    inst_wdata    = IW;
    inst_uncached = 1'b0;
    data_size     = 2'd0;
    data_addr     = DA;
    data_wdata    = DW;
    data_uncached = 1'b1;
    s_rdata       = 32'hCAFE_F00D;

    // Rows are consecutive IDLE cycles; zero-latency handshakes keep the FSM in IDLE.
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h1111_1111, 5'b00000, 32'h0, 32'h0, 2'd0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 32'h2222_2222, 5'b00000, 32'h0, 32'h0, 2'd0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 32'h3333_3333, 5'b00000, 32'h0, 32'h0, 2'd0, 0, 0};
    vecs[3]  = '{1, 0, 1, 0, 1, 1, 32'h0000_0003, 5'b11010, IA, IW, 2'd2, 1, 0};
    vecs[4]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0004, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[5]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0005, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[6]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0006, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[7]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0007, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[8]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0008, 5'b11010, IA, IW, 2'd2, 1, 0};
    vecs[9]  = '{1, 1, 1, 0, 1, 1, 32'h0000_0009, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[10] = '{0, 1, 0, 1, 1, 1, 32'h0000_000A, 5'b10101, DA, DW, 2'd0, 1, 1};
    vecs[11] = '{1, 1, 1, 0, 1, 1, 32'h0000_000B, 5'b10101, DA, DW, 2'd0, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 32'h0000_000C, 5'b00000, 32'h0, 32'h0, 2'd0, 0, 0};

    // Reset values, checked while reset is held.
    rst       = 1'b0;
    inst_req  = 1'b0;
    data_req  = 1'b0;
    inst_wr   = 1'b0;
    data_wr   = 1'b0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    #12;
    chk("rst oks", 32'(oks()), 32'd0);
    chk("rst s_addr", s_addr, 32'd0);
    chk("rst s_wdata", s_wdata, 32'd0);
    chk("rst s_misc", 32'({s_wr, s_size, s_uncached}), 32'd0);
    chk("rst inst_rdata", inst_rdata, 32'hCAFE_F00D);
    chk("rst starve", 32'(dut.starve_cnt_q), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table: idle/protocol-error cycles, zero-latency issue, starvation rotation.
    for (int i = 0; i < NV; i++) begin
      inst_req  = vecs[i].ireq;
      data_req  = vecs[i].dreq;
      inst_wr   = vecs[i].iwr;
      data_wr   = vecs[i].dwr;
      s_addr_ok = vecs[i].sa;
      s_data_ok = vecs[i].sd;
      s_rdata   = vecs[i].srd;
      @(negedge clk);
      chk($sformatf("vec%0d oks", i), 32'(oks()), 32'(vecs[i].ok));
      chk($sformatf("vec%0d s_addr", i), s_addr, vecs[i].saddr);
      chk($sformatf("vec%0d s_wdata", i), s_wdata, vecs[i].swdata);
      chk($sformatf("vec%0d s_ctl", i), 32'({s_size, s_wr, s_uncached}),
          32'({vecs[i].ssize, vecs[i].swr, vecs[i].sunc}));
      chk($sformatf("vec%0d inst_rdata", i), inst_rdata, vecs[i].srd);
      @(posedge clk);
      #1;
    end

    // Data-only LW: addr_ok two cycles late, data_ok three cycles after that.
    do_reset();
    data_size = 2'd2;
    data_req  = 1'b1;
    step("a0", 0, 0, 32'h0, 5'b10000, DA, 0);
    step("a1", 0, 0, 32'h0, 5'b10000, DA, 0);
    step("a2", 1, 0, 32'h0, 5'b10100, DA, 0);
    data_req = 1'b0;
    step("a3", 0, 0, 32'h0, 5'b00000, 32'h0, 0);
    step("a4", 0, 0, 32'h0, 5'b00000, 32'h0, 0);
    step("a5", 0, 1, 32'hDEAD_BEEF, 5'b00001, 32'h0, 0);
    step("a6", 0, 0, 32'h0, 5'b00000, 32'h0, 0);

    // Simultaneous requests: data first, inst right after data completes.
    do_reset();
    inst_req = 1'b1;
    data_req = 1'b1;
    step("b0", 1, 0, 32'h0, 5'b10100, DA, 0);
    data_req = 1'b0;
    chk("b starve=1", 32'(dut.starve_cnt_q), 32'd1);
    step("b1", 0, 0, 32'h0, 5'b00000, 32'h0, 0);
    step("b2", 0, 1, 32'hDEAD_BEEF, 5'b00001, 32'h0, 0);
    step("b3", 1, 0, 32'h0, 5'b11000, IA, 0);
    inst_req = 1'b0;
    chk("b starve=0", 32'(dut.starve_cnt_q), 32'd0);
    step("b4", 0, 1, 32'h0BAD_F00D, 5'b00010, 32'h0, 0);

    // Grant stays locked to inst while the slave withholds addr_ok.
    do_reset();
    inst_req = 1'b1;
    inst_wr  = 1'b1;
    step("c0", 0, 0, 32'h0, 5'b10000, IA, 1);
    data_req = 1'b1;
    step("c1", 0, 0, 32'h0, 5'b10000, IA, 1);
    step("c2", 0, 0, 32'h0, 5'b10000, IA, 1);
    step("c3", 0, 0, 32'h0, 5'b10000, IA, 1);
    step("c4", 1, 0, 32'h0, 5'b11000, IA, 1);
    inst_req = 1'b0;
    step("c5", 0, 1, 32'h0, 5'b00010, 32'h0, 0);
    step("c6", 1, 1, 32'h7777_0006, 5'b10101, DA, 0);
    data_req = 1'b0;
    step("c7", 0, 0, 32'h0, 5'b00000, 32'h0, 0);

    // Asynchronous reset in WAIT_DATA drops the transaction.
    do_reset();
    data_req = 1'b1;
    step("e0", 1, 0, 32'h0, 5'b10100, DA, 0);
    data_req  = 1'b0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("e rst oks", 32'(oks()), 32'd0);
    chk("e rst s_addr", s_addr, 32'd0);
    s_data_ok = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("e late", 0, 1, 32'h0, 5'b00000, 32'h0, 0);
    inst_req = 1'b1;
    inst_wr  = 1'b1;
    step("e next", 1, 1, 32'h0, 5'b11010, IA, 1);
    inst_req = 1'b0;
    step("e idle", 0, 0, 32'h0, 5'b00000, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
